switch_debounce: RTL and testbench
==================================

# switch_debounce

Input conditioner sitting between the 8 input switches and the counter/7-segment stage. It synchronises the raw switch vector into `clk`, debounces it as a whole vector with a settle-time counter, and publishes a clean registered value plus single-cycle change pulses. Downstream logic, such as the compare-count selection, consumes the debounced value instead of raw pins.

## Interface
Parameters:
- `WIDTH`, 8, number of switch bits.
- `CNT_W`, 24, settle-counter width in bits.
- `DEBOUNCE_CYCLES`, 24'd100_000, stable cycles required before commit. This is 10 ms at 10 MHz. Legal range is 1 to 2^CNT_W−1.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sw_in` input WIDTH: raw, asynchronous switch levels.
- `sw_out` output WIDTH: debounced, registered switch value.
- `sw_rise` output WIDTH: one-cycle pulse per bit that committed 0→1.
- `sw_fall` output WIDTH: one-cycle pulse per bit that committed 1→0.
- `changed` output 1: one-cycle pulse on every commit. Equals OR of `sw_rise | sw_fall`, registered.
- `stable` output 1: high when the FSM is in IDLE.

## Operation
- **Synchroniser:** two-flop chain per bit, `sw_in` → `s1` → `s2`. Both stages reset to 0.
- **FSM states:** IDLE and SETTLING. Internal `cand` (WIDTH) and `cnt` (CNT_W) both reset to 0.
- **IDLE:**
  - If `s2 != sw_out`: `cand <= s2`, `cnt <= 0`, go to SETTLING.
  - Otherwise hold.
- **SETTLING**, conditions evaluated in priority order:
  1. `s2 == sw_out` (bounce returned to the committed value): go to IDLE, `cnt <= 0`, no pulses.
  2. `s2 != cand` (new intermediate value): `cand <= s2`, `cnt <= 0`, stay in SETTLING.
  3. `cnt == DEBOUNCE_CYCLES−1`: commit. `sw_out <= cand`, `sw_rise <= cand & ~sw_out`, `sw_fall <= ~cand & sw_out`, `changed <= 1`, go to IDLE.
  4. Otherwise `cnt <= cnt + 1`. The counter never wraps because commit occurs first.
- **Multi-bit changes:** all bits commit together in one cycle, so partial-vector commits are impossible.
- **Pulses:** `sw_rise`, `sw_fall` and `changed` are 0 in every cycle except the commit cycle.
- **Reset values:** `sw_out`=0, `sw_rise`=0, `sw_fall`=0, `changed`=0, `stable`=1. Asserting `rst_n` mid-settle aborts immediately and returns to these values. A switch already high at reset release is treated as a normal change and commits after the settle time.

## Timing
- Take a raw change at edge 0 that stays stable:
  - `s2` reflects it after edge 2.
  - SETTLING is entered at edge 3 with `cnt`=0.
  - Commit happens at edge `DEBOUNCE_CYCLES+3`. `sw_out` and the pulses are visible in the following cycle.
- Total latency is `DEBOUNCE_CYCLES+3` clocks. Pulses last exactly one cycle.
- `stable` goes low the cycle after edge 3 and high again in the same cycle as the commit.
- Any `s2` change during SETTLING restarts the full `DEBOUNCE_CYCLES` window.

## Configuration
- **Macro `SWDB_EDGES_EN`:**
  - Defined: `sw_rise`, `sw_fall` and `changed` are generated as described above.
  - Undefined: the three outputs are tied to 0 and their registers are removed. `sw_out`, `stable` and the timing are unchanged.

## Structure
- **Shared package `swdb_pkg`:** the state enum (IDLE, SETTLING), `SWDB_CNT_W_DEFAULT` = 24, and `SWDB_DEBOUNCE_DEFAULT` = 100_000.
- **Sub-module `sync_2ff`:** parameterised by WIDTH, reset to 0, instantiated once for the synchroniser.
- The FSM, counter and output registers live in `switch_debounce` itself.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SWDB_EDGES_EN` defined.
- **Clean change:** hold `sw_in`=0x00 after reset, then step to 0x2A. `sw_out`=0x2A exactly 7 clocks later, `sw_rise`=0x2A and `changed`=1 for one cycle, `stable` low for 4 cycles.
- **Restart on change:** step 0x00→0x01, then after 2 clocks step to 0x03. The commit of 0x03 lands 7 clocks after the second step, and 0x01 is never output.
- **Bounce back:** step 0x00→0x80, then return to 0x00 after 2 clocks. No pulses, `sw_out` stays 0x00, and `stable` returns high with no commit.
- **Release:** from committed 0xFF, step to 0x0F. `sw_fall`=0xF0, `sw_rise`=0x00, `sw_out`=0x0F after 7 clocks.
- **Reset mid-settle:** assert `rst_n`=0 asynchronously while in SETTLING. All outputs return to reset values immediately. After release with `sw_in`=0x05, commit to 0x05 occurs 7 clocks later.
- **Edges compiled out:** rebuild without `SWDB_EDGES_EN` and repeat the first scenario. `sw_out` timing is identical, and `sw_rise`, `sw_fall` and `changed` stay 0 throughout.

Source files
------------

// File: rtl/swdb_pkg.sv
// Shared types and defaults for the switch debouncer.
package swdb_pkg;
  localparam int SWDB_CNT_W_DEFAULT    = 24;
  localparam int SWDB_DEBOUNCE_DEFAULT = 100_000;

  typedef enum logic {IDLE, SETTLING} swdb_state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous levels, reset to 0.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/switch_debounce.sv
// Whole-vector switch debouncer: sync, settle-time FSM, registered value and change pulses.
// Optional macro SWDB_EDGES_EN enables sw_rise/sw_fall/changed; otherwise they are tied to 0.
module switch_debounce
  import swdb_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int CNT_W           = SWDB_CNT_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SWDB_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed,
  output logic             stable
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  swdb_state_e      state_q, state_d;
  logic             commit;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw_in),
    .q    (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      sw_out  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      if (commit) sw_out <= cand_q;
    end
  end

  // Any movement of s2 away from the candidate restarts the full window.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2 != sw_out) begin
          cand_d  = s2;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (s2 == sw_out) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s2 != cand_q) begin
          cand_d = s2;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stable = (state_q == IDLE);

`ifdef SWDB_EDGES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rise <= '0;
      sw_fall <= '0;
      changed <= 1'b0;
    end else begin
      sw_rise <= commit ? (cand_q & ~sw_out) : '0;
      sw_fall <= commit ? (~cand_q & sw_out) : '0;
      changed <= commit;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
  assign changed = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with a short settle window.
module tb_switch_debounce;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_in;
  logic [7:0] sw_out, sw_rise, sw_fall;
  logic       changed, stable;

  exp_t       sb[$];
  logic [7:0] model_out;
  logic [7:0] prev_out;
  int         cyc = 0;
  int         stable_lo = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  switch_debounce #(.WIDTH(8), .CNT_W(24), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed),
    .stable (stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    sw_in = v;
  endtask

  // Expect v to be committed LAT edges after the current one.
  task automatic push(input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + LAT;
    e.val = v;
`ifdef SWDB_EDGES_EN
    e.rise = v & ~model_out;
    e.fall = ~v & model_out;
    e.chg  = 1'b1;
`else
    e.rise = 8'h00;
    e.fall = 8'h00;
    e.chg  = 1'b0;
`endif
    sb.push_back(e);
    model_out = v;
  endtask

  // A commit is recognised by sw_out moving; pulses must be quiet otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = 8'h00;
    end else begin
      if (!stable) stable_lo++;
      if (sw_out !== prev_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", {24'h0, sw_out}, {24'h0, prev_out});
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("sw_out", {24'h0, sw_out}, {24'h0, e.val});
          chk("sw_rise", {24'h0, sw_rise}, {24'h0, e.rise});
          chk("sw_fall", {24'h0, sw_fall}, {24'h0, e.fall});
          chk("changed", {31'h0, changed}, {31'h0, e.chg});
          chk("stable_at_commit", {31'h0, stable}, 32'h1);
        end
      end else begin
        chk("rise_quiet", {24'h0, sw_rise}, 32'h0);
        chk("fall_quiet", {24'h0, sw_fall}, 32'h0);
        chk("changed_quiet", {31'h0, changed}, 32'h0);
      end
      prev_out = sw_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    sw_in     = 8'h00;
    model_out = 8'h00;
    prev_out  = 8'h00;
    wait_cyc(2);
    chk("rst_sw_out", {24'h0, sw_out}, 32'h0);
    chk("rst_rise", {24'h0, sw_rise}, 32'h0);
    chk("rst_fall", {24'h0, sw_fall}, 32'h0);
    chk("rst_changed", {31'h0, changed}, 32'h0);
    chk("rst_stable", {31'h0, stable}, 32'h1);
    rst_n = 1'b1;
    wait_cyc(3);

    // Clean change
    stable_lo = 0;
    drive(8'h2A); push(8'h2A);
    wait_cyc(10);
    chk("clean_stable_low", stable_lo, 4);
    drive(8'h00); push(8'h00);
    wait_cyc(10);

    // Restart on change: 0x01 must never be committed
    drive(8'h01);
    wait_cyc(2);
    drive(8'h03); push(8'h03);
    wait_cyc(10);
    drive(8'h00); push(8'h00);
    wait_cyc(10);

    // Bounce back to committed value
    stable_lo = 0;
    drive(8'h80);
    wait_cyc(2);
    drive(8'h00);
    wait_cyc(10);
    chk("bounce_stable_low", stable_lo, 2);
    chk("bounce_sw_out", {24'h0, sw_out}, 32'h0);

    // Release from all-ones
    drive(8'hFF); push(8'hFF);
    wait_cyc(10);
    drive(8'h0F); push(8'h0F);
    wait_cyc(10);

    // Asynchronous reset in the middle of settling
    drive(8'h3C);
    wait_cyc(4);
    chk("pre_rst_settling", {31'h0, stable}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_sw_out", {24'h0, sw_out}, 32'h0);
    chk("arst_rise", {24'h0, sw_rise}, 32'h0);
    chk("arst_fall", {24'h0, sw_fall}, 32'h0);
    chk("arst_changed", {31'h0, changed}, 32'h0);
    chk("arst_stable", {31'h0, stable}, 32'h1);
    model_out = 8'h00;
    drive(8'h05);
    wait_cyc(1);
    rst_n = 1'b1;
    push(8'h05);
    wait_cyc(10);

    for (int i = 0; i < 20 && sb.size() != 0; i++) wait_cyc(1);
    chk("sb_empty", sb.size(), 0);
    chk("final_sw_out", {24'h0, sw_out}, 32'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
